hfosc_tick_gen: RTL and testbench
=================================

# hfosc_tick_gen

Timebase stage directly downstream of the iCE40 high-frequency oscillator (SB_HFOSC). Runs on the oscillator output clock. Holds a `ready` flag low until a fixed settle interval has elapsed after reset, then emits a single-cycle `tick` strobe at `TICK_HZ` regardless of the oscillator divider setting `div_sel`. All timer, UART-baud and LED logic in the design consumes `ready`/`tick` instead of raw clock counts.

## Interface
- `CLK_HZ`, 48000000, undivided oscillator frequency (`div_sel` = 0).
- `TICK_HZ`, 1000, tick strobe rate.
- `SETTLE_CYCLES`, 4800, clock cycles from reset release to `ready`.
- Elaboration error if `CLK_HZ/TICK_HZ` > 65536 or < 2, or if `SETTLE_CYCLES` = 0.
- `clk`  in  1  oscillator output clock (CLKHF).
- `rst`  in  1  reset; synchronous, active-high.
- `div_sel`  in  2  oscillator divider code. Matches CLKHF_DIV encoding: 0 → ÷1, 1 → ÷2, 2 → ÷4, 3 → ÷8.
- `ready`  out  1  settle interval complete; level.
- `tick`  out  1  one-cycle strobe at `TICK_HZ`.
- `tick_cnt`  out  16  free-running tick count.

## Operation
- Effective clock `f = CLK_HZ >> div_sel`.
- Prescaler reload `R = f/TICK_HZ − 1`, integer division with truncation. The prescaler is 16 bits.
- States:
  - `SETTLE`: entered on reset. The 16-bit settle counter increments each cycle. The transition to `RUN` occurs when the count reaches `SETTLE_CYCLES − 1`.
  - `RUN`: terminal state. Leaves only on `rst`.
- On entering `RUN`, the prescaler is loaded with `R`.
- In `RUN`, the prescaler decrements each cycle. At 0 it:
  - asserts `tick` for one cycle,
  - reloads `R`,
  - increments `tick_cnt`.
- `tick_cnt` wraps from 65535 to 0 with no flag.
- `div_sel` is registered once, with no synchronizer; it is the same-clock configuration.
- A change in the registered value reloads the prescaler with the new `R` and restarts the period.
  - If a change and a prescaler zero occur in the same cycle, the change wins: `tick` is suppressed and `tick_cnt` holds.
  - A change during `SETTLE` affects nothing except the `R` loaded on entry to `RUN`.
- `tick` and `tick_cnt` are inert in `SETTLE`.

## Timing
- Reset values, taking effect on the first edge with `rst` = 1:
  - `ready` = 0, `tick` = 0, `tick_cnt` = 0
  - state = `SETTLE`, settle count = 0, prescaler = 0
- `ready` rises on the `SETTLE_CYCLES`-th rising edge with `rst` = 0. It is registered and glitch-free.
- First `tick` occurs `R + 1` cycles after the edge on which `ready` rose.
- After that, `tick` repeats every `R + 1` cycles.
- `tick_cnt` updates on the same edge that `tick` asserts.
- After a `div_sel` change:
  - 1 cycle of register latency,
  - then the next `tick` arrives `R_new + 1` cycles after the reload.
- `rst` mid-`RUN`: everything returns to reset values on the next edge and the full settle interval restarts.
- `rst` dominates all other events.

## Configuration
- `HFOSC_TICK_SEC_EN` defined:
  - Adds output `sec_tick` (1 bit, reset 0) and an internal sub-counter of width `$clog2(TICK_HZ)`.
  - The sub-counter counts `tick`s and wraps at `TICK_HZ − 1`.
  - `sec_tick` pulses on the same cycle as every `TICK_HZ`-th `tick`, starting with the `TICK_HZ`-th tick after `ready`.
  - A `div_sel`-suppressed tick is not counted.
- `HFOSC_TICK_SEC_EN` undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Package `hfosc_pkg` holds:
  - `HFOSC_CLK_HZ` = 48000000.
  - `div_sel` code localparams `HFOSC_DIV1`..`HFOSC_DIV8`.
  - State enum `hfosc_state_t` {`SETTLE`, `RUN`}.
  - Function `hfosc_reload(clk_hz, tick_hz, div_sel)` returning a 16-bit `R`.
- Sub-module `hfosc_settle` contains the settle counter and the `ready` register, with ports `clk`, `rst`, `ready`.
- The top level contains the prescaler, `div_sel` change detect, `tick_cnt` and the optional seconds counter.

## Test plan
Parameters: `CLK_HZ` = 48000, `TICK_HZ` = 1000, `SETTLE_CYCLES` = 8, `HFOSC_TICK_SEC_EN` defined.

1. `rst` high for 3 cycles, then low with `div_sel` = 0 → `ready` rises on the 8th edge after release; first `tick` 48 cycles later; then every 48 cycles; `tick_cnt` = 1, 2, 3.
2. `div_sel` = 3 from reset (`R` = 5) → `tick` every 6 cycles after `ready`; `tick_cnt` reaches 10 after 60 cycles.
3. `div_sel` 0 → 1 while the prescaler holds 20 → no tick at the old boundary; next `tick` 24 cycles after the reload; `tick_cnt` unchanged until then.
4. `div_sel` change landing exactly on the prescaler-zero cycle → `tick` stays 0 that cycle; `tick_cnt` holds; `sec_tick` sub-counter does not advance.
5. Force `tick_cnt` to 65535 via run length (`div_sel` = 3) → next `tick` gives `tick_cnt` = 0; `sec_tick` fires on ticks 1000, 2000, …
6. `rst` pulsed 1 cycle mid-`RUN` → `ready` = 0, `tick_cnt` = 0 next edge; `ready` re-rises 8 edges after release.

Source files
------------

// File: rtl/hfosc_pkg.sv
// Shared constants, state type and reload helper for the HFOSC tick generator.
package hfosc_pkg;

  localparam int unsigned HFOSC_CLK_HZ = 32'd48000000;

  localparam logic [1:0] HFOSC_DIV1 = 2'd0;
  localparam logic [1:0] HFOSC_DIV2 = 2'd1;
  localparam logic [1:0] HFOSC_DIV4 = 2'd2;
  localparam logic [1:0] HFOSC_DIV8 = 2'd3;

  typedef enum logic {
    SETTLE = 1'b0,
    RUN    = 1'b1
  } hfosc_state_t;

  // Prescaler reload for one divider code; clamps to 0 if the divided clock is below TICK_HZ.
  function automatic logic [15:0] hfosc_reload(input int unsigned clk_hz,
                                               input int unsigned tick_hz,
                                               input logic [1:0]  div_sel);
    int unsigned f;
    int unsigned q;
    f = clk_hz >> div_sel;
    q = f / tick_hz;
    if (q == 32'd0) begin
      hfosc_reload = 16'd0;
    end else begin
      hfosc_reload = 16'(q - 32'd1);
    end
  endfunction

endpackage

// File: rtl/hfosc_settle.sv
// Settle timer: holds ready low for SETTLE_CYCLES clocks after reset release, then latches it high.
module hfosc_settle
  import hfosc_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 32'd4800
) (
  input  logic clk,
  input  logic rst,
  output logic ready
);

  localparam logic [15:0] LAST = 16'(SETTLE_CYCLES - 32'd1);

  hfosc_state_t state;
  hfosc_state_t state_next;
  logic [15:0]  count;
  logic [15:0]  count_next;
  logic         ready_next;

  // State, settle count and ready register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SETTLE;
      count <= 16'd0;
      ready <= 1'b0;
    end else begin
      state <= state_next;
      count <= count_next;
      ready <= ready_next;
    end
  end

  // Next-state decode
  always_comb begin
    state_next = state;
    case (state)
      SETTLE: begin
        if (count == LAST) begin
          state_next = RUN;
        end else begin
          state_next = SETTLE;
        end
      end
      RUN:     state_next = RUN;
      default: state_next = SETTLE;
    endcase
  end

  // Counter advance and ready decode; ready is taken from the next state so it is a clean flop output
  always_comb begin
    count_next = count;
    ready_next = 1'b0;
    case (state)
      SETTLE: begin
        if (count == LAST) begin
          count_next = count;
        end else begin
          count_next = count + 16'd1;
        end
        ready_next = (state_next == RUN);
      end
      RUN: begin
        count_next = count;
        ready_next = 1'b1;
      end
      default: begin
        count_next = 16'd0;
        ready_next = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/hfosc_tick_gen.sv
// TICK_HZ strobe generator behind SB_HFOSC, independent of the CLKHF divider setting.
// Define HFOSC_TICK_SEC_EN to add the once-per-second sec_tick output.
module hfosc_tick_gen
  import hfosc_pkg::*;
#(
  parameter int unsigned CLK_HZ        = HFOSC_CLK_HZ,
  parameter int unsigned TICK_HZ       = 32'd1000,
  parameter int unsigned SETTLE_CYCLES = 32'd4800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  div_sel,
  output logic        ready,
  output logic        tick,
`ifdef HFOSC_TICK_SEC_EN
  output logic        sec_tick,
`endif
  output logic [15:0] tick_cnt
);

  localparam int unsigned RATIO = CLK_HZ / TICK_HZ;

  generate
    if (RATIO > 32'd65536 || RATIO < 32'd2) begin : g_bad_ratio
      $error("hfosc_tick_gen: CLK_HZ/TICK_HZ must be within 2..65536");
    end
    if (SETTLE_CYCLES == 32'd0 || SETTLE_CYCLES > 32'd65536) begin : g_bad_settle
      $error("hfosc_tick_gen: SETTLE_CYCLES must be within 1..65536");
    end
  endgenerate

  // One reload constant per divider code, so no runtime divider is built
  localparam logic [15:0] RLD_DIV1 = hfosc_reload(CLK_HZ, TICK_HZ, HFOSC_DIV1);
  localparam logic [15:0] RLD_DIV2 = hfosc_reload(CLK_HZ, TICK_HZ, HFOSC_DIV2);
  localparam logic [15:0] RLD_DIV4 = hfosc_reload(CLK_HZ, TICK_HZ, HFOSC_DIV4);
  localparam logic [15:0] RLD_DIV8 = hfosc_reload(CLK_HZ, TICK_HZ, HFOSC_DIV8);

  logic [1:0]  div_r;
  logic [1:0]  div_d;
  logic        div_chg;
  logic [15:0] reload;
  logic [15:0] presc;
  logic        tick_fire;

  hfosc_settle #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle (
    .clk  (clk),
    .rst  (rst),
    .ready(ready)
  );

  // div_sel is same-clock configuration: one capture stage plus a delayed copy for change detect
  always_ff @(posedge clk) begin
    if (rst) begin
      div_r <= div_sel;
      div_d <= div_sel;
    end else begin
      div_r <= div_sel;
      div_d <= div_r;
    end
  end

  assign div_chg = (div_r != div_d);

  // Reload value for the captured divider code
  always_comb begin
    reload = RLD_DIV1;
    case (div_r)
      HFOSC_DIV1: reload = RLD_DIV1;
      HFOSC_DIV2: reload = RLD_DIV2;
      HFOSC_DIV4: reload = RLD_DIV4;
      HFOSC_DIV8: reload = RLD_DIV8;
      default:    reload = RLD_DIV1;
    endcase
  end

  // A divider change outranks a coinciding prescaler zero
  assign tick_fire = ready && !div_chg && (presc == 16'd0);

  // Prescaler, tick strobe and tick counter; held at reload throughout SETTLE so RUN starts a full period
  always_ff @(posedge clk) begin
    if (rst) begin
      presc    <= 16'd0;
      tick     <= 1'b0;
      tick_cnt <= 16'd0;
    end else if (!ready || div_chg) begin
      presc    <= reload;
      tick     <= 1'b0;
    end else if (tick_fire) begin
      presc    <= reload;
      tick     <= 1'b1;
      tick_cnt <= tick_cnt + 16'd1;
    end else begin
      presc    <= presc - 16'd1;
      tick     <= 1'b0;
    end
  end

`ifdef HFOSC_TICK_SEC_EN
  localparam int unsigned      SUB_W    = (TICK_HZ > 32'd1) ? $clog2(TICK_HZ) : 32'd1;
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(TICK_HZ - 32'd1);

  logic [SUB_W-1:0] sub_cnt;

  // Seconds sub-counter: counts delivered ticks only, pulses on every TICK_HZ-th one
  always_ff @(posedge clk) begin
    if (rst) begin
      sub_cnt  <= '0;
      sec_tick <= 1'b0;
    end else if (tick_fire) begin
      if (sub_cnt == SUB_LAST) begin
        sub_cnt  <= '0;
        sec_tick <= 1'b1;
      end else begin
        sub_cnt  <= sub_cnt + SUB_W'(1);
        sec_tick <= 1'b0;
      end
    end else begin
      sec_tick <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_hfosc_tick_gen.sv
// Self-checking bench for hfosc_tick_gen: directed scenarios with literal expectations
// plus a randomized run, all cross-checked every cycle against an event-time model.
module tb_hfosc_tick_gen;

  localparam int unsigned CLK_HZ  = 48000;
  localparam int unsigned TICK_HZ = 1000;
  localparam int unsigned SETTLE  = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  div_sel;
  logic        ready;
  logic        tick;
  logic [15:0] tick_cnt;
`ifdef HFOSC_TICK_SEC_EN
  logic        sec_tick;
`endif

  int n_checks = 0;
  int n_errors = 0;

  hfosc_tick_gen #(
    .CLK_HZ       (CLK_HZ),
    .TICK_HZ      (TICK_HZ),
    .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .div_sel (div_sel),
    .ready   (ready),
    .tick    (tick),
`ifdef HFOSC_TICK_SEC_EN
    .sec_tick(sec_tick),
`endif
    .tick_cnt(tick_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks time of the current period start (in edges) and the period length.
  function automatic int period_of(input int d);
    return ((CLK_HZ >> d) / TICK_HZ);
  endfunction

  int  edge_n = 0;
  bit  m_valid = 0;
  int  m_rdy, m_tick, m_cnt, m_sec, m_ticks, m_settled;
  int  m_start, m_period;
  int  m_div_now, m_div_prev;

  task automatic model_step();
    int prev_rdy;
    edge_n++;
    if (rst === 1'b1) begin
      m_valid   = 1;
      m_rdy     = 0; m_tick = 0; m_cnt = 0; m_sec = 0;
      m_ticks   = 0; m_settled = 0;
      m_div_now = div_sel; m_div_prev = div_sel;
      return;
    end
    prev_rdy = m_rdy;
    m_tick = 0;
    m_sec  = 0;
    if (!prev_rdy) begin
      m_settled++;
      if (m_settled == SETTLE) begin
        m_rdy    = 1;
        m_start  = edge_n;
        m_period = period_of(m_div_now);
      end
    end else if (m_div_now != m_div_prev) begin
      m_start  = edge_n;
      m_period = period_of(m_div_now);
    end else if (edge_n - m_start == m_period) begin
      m_tick  = 1;
      m_cnt   = (m_cnt + 1) % 65536;
      m_ticks++;
      m_sec   = (m_ticks % TICK_HZ == 0) ? 1 : 0;
      m_start = edge_n;
    end
    m_div_prev = m_div_now;
    m_div_now  = div_sel;
  endtask

  always @(posedge clk) model_step();

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (m_valid) begin
      check("m_ready", ready, m_rdy);
      check("m_tick", tick, m_tick);
      check("m_tick_cnt", tick_cnt, m_cnt);
`ifdef HFOSC_TICK_SEC_EN
      check("m_sec_tick", sec_tick, m_sec);
`endif
    end
  end

  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic reset_run(input logic [1:0] d, input int len);
    rst = 1'b1;
    div_sel = d;
    cyc(len);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    div_sel = 2'd0;

    // 1: divide-by-1, R = 47
    reset_run(2'd0, 3);
    check("t1_reset_ready", ready, 0);
    check("t1_reset_cnt", tick_cnt, 0);
    cyc(7);
    check("t1_ready_edge7", ready, 0);
    cyc(1);
    check("t1_ready_edge8", ready, 1);
    for (int i = 1; i <= 3; i++) begin
      cyc(47);
      check("t1_no_tick", tick, 0);
      cyc(1);
      check("t1_tick", tick, 1);
      check("t1_cnt", tick_cnt, i);
    end

    // 2: divide-by-8 from reset, R = 5
    reset_run(2'd3, 2);
    cyc(8);
    check("t2_ready", ready, 1);
    cyc(60);
    check("t2_tick", tick, 1);
    check("t2_cnt10", tick_cnt, 10);

    // 3: 0 -> 1 while prescaler holds 20; reload lands two edges after the input change
    reset_run(2'd0, 2);
    cyc(8);
    cyc(26);
    div_sel = 2'd1;
    cyc(25);
    check("t3_no_old_tick_cnt", tick_cnt, 0);
    check("t3_no_tick", tick, 0);
    cyc(1);
    check("t3_tick", tick, 1);
    check("t3_cnt", tick_cnt, 1);

    // 4: change lands on the prescaler-zero edge, then run to the 1000th tick
    reset_run(2'd3, 2);
    cyc(8);
    cyc(10);
    div_sel = 2'd2;
    cyc(2);
    check("t4_suppressed", tick, 0);
    check("t4_cnt_hold", tick_cnt, 1);
    cyc(11);
    check("t4_no_tick", tick, 0);
    cyc(1);
    check("t4_tick", tick, 1);
    check("t4_cnt", tick_cnt, 2);
    cyc(12 * 998);
    check("t4_tick1000", tick, 1);
    check("t4_cnt1000", tick_cnt, 1000);
`ifdef HFOSC_TICK_SEC_EN
    check("t4_sec_tick", sec_tick, 1);
`endif

    // 6: one-cycle reset mid-RUN
    rst = 1'b1;
    cyc(1);
    check("t6_ready_low", ready, 0);
    check("t6_cnt_zero", tick_cnt, 0);
    rst = 1'b0;
    cyc(7);
    check("t6_ready_edge7", ready, 0);
    cyc(1);
    check("t6_ready_edge8", ready, 1);

    // Randomized run: sparse divider changes and occasional resets
    for (int i = 0; i < 20000; i++) begin
      cyc(1);
      if ($urandom_range(0, 99) < 2) div_sel = 2'($urandom_range(0, 3));
      rst = ($urandom_range(0, 1999) == 0) ? 1'b1 : 1'b0;
    end
    rst = 1'b0;
    cyc(100);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
